alu_result_stage: RTL and testbench

//  Registered stage directly downstream of the 16-bit ripple-carry adder/subtractor.
//  - Captures Sum/Carry/Overflow/sel and derives the N/Z/C/V flags.
//  - Buffers results in a 2-entry skid buffer under a valid/ready handshake.
//  - Holds an accumulator that is fed back upstream as operand A, plus a sticky overflow flag.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/result_skid_buffer.sv | 69 ++++++
 rtl/alu_result_stage.sv | 83 ++++++++
 tb/tb_alu_result_stage.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result stage: datapath width,
// flag bit positions, the buffered entry record and occupancy encodings.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  typedef struct packed {
    logic                 op;
    logic [3:0]           flags;
    logic [ALU_WIDTH-1:0] result;
  } entry_t;

endpackage

// File: rtl/result_skid_buffer.sv
// Two-entry FIFO of result entries. Head lives in slot 0; a pop shifts slot 1 down.
//   state     | meaning
//   OCC_EMPTY | no entries, o_valid=0
//   OCC_ONE   | head in slot 0
//   OCC_FULL  | head in slot 0, second in slot 1, o_ready=0
module result_skid_buffer
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  output logic       o_ready,
  input  entry_t     i_data,
  output logic       o_valid,
  input  logic       i_pop_ready,
  output entry_t     o_data,
  output logic [1:0] o_count
);

  occ_e   r_occ;
  occ_e   w_occ_next;
  entry_t r_slot0;
  entry_t r_slot1;
  logic   w_accept;
  logic   w_pop;

  assign w_accept = i_push & o_ready;
  assign w_pop    = o_valid & i_pop_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_occ <= OCC_EMPTY;
    else        r_occ <= w_occ_next;
  end

  always_comb begin
    w_occ_next = r_occ;
    case (r_occ)
      OCC_EMPTY: if (w_accept) w_occ_next = OCC_ONE;
      OCC_ONE: begin
        if (w_accept && !w_pop)      w_occ_next = OCC_FULL;
        else if (!w_accept && w_pop) w_occ_next = OCC_EMPTY;
      end
      OCC_FULL:  if (w_pop) w_occ_next = OCC_ONE;
      default:   w_occ_next = OCC_EMPTY;
    endcase
  end

  always_comb begin
    o_ready = (r_occ != OCC_FULL);
    o_valid = (r_occ != OCC_EMPTY);
    o_count = r_occ;
    o_data  = r_slot0;
  end

  // When full, no push can be accepted, so a pop only ever shifts slot 1 down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot0 <= '0;
      r_slot1 <= '0;
    end else if (w_pop) begin
      if (r_occ == OCC_FULL) r_slot0 <= r_slot1;
      else if (w_accept)     r_slot0 <= i_data;
    end else if (w_accept) begin
      if (r_occ == OCC_EMPTY) r_slot0 <= i_data;
      else                    r_slot1 <= i_data;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered stage after the adder/subtractor: derives N/Z/C/V, buffers results
// in a 2-entry skid buffer, and keeps the accumulator and sticky overflow.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Sum,
  input  logic             Carry,
  input  logic             Overflow,
  input  logic             sel,
  input  logic             acc_load,
  input  logic             sticky_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       Flags,
  output logic             Op,
  output logic [WIDTH-1:0] Acc,
  output logic             StickyV,
  output logic [1:0]       Occupancy
);

  logic             w_accept;
  logic [3:0]       w_flags;
  entry_t           w_entry_in;
  entry_t           w_entry_out;
  logic [WIDTH-1:0] r_acc;
  logic             r_sticky_v;

  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_flags         = '0;
    w_flags[FLAG_N] = Sum[WIDTH-1];
    w_flags[FLAG_Z] = ~|Sum;
    w_flags[FLAG_C] = Carry;
    w_flags[FLAG_V] = Overflow;
  end

  always_comb begin
    w_entry_in        = '0;
    w_entry_in.op     = sel;
    w_entry_in.flags  = w_flags;
    w_entry_in.result = Sum;
  end

  result_skid_buffer u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (in_valid),
    .o_ready     (in_ready),
    .i_data      (w_entry_in),
    .o_valid     (out_valid),
    .i_pop_ready (out_ready),
    .o_data      (w_entry_out),
    .o_count     (Occupancy)
  );

  assign Result = w_entry_out.result;
  assign Flags  = w_entry_out.flags;
  assign Op     = w_entry_out.op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_acc <= '0;
    else if (w_accept && acc_load) r_acc <= Sum;
  end

  // Set has priority over clear so a same-cycle overflow is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_sticky_v <= 1'b0;
    else if (w_accept && Overflow) r_sticky_v <= 1'b1;
    else if (sticky_clr)           r_sticky_v <= 1'b0;
  end

  assign Acc     = r_acc;
  assign StickyV = r_sticky_v;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed table-driven bench for alu_result_stage plus hand sequences
// for streaming and asynchronous reset with a full buffer.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, Carry, Overflow, sel, acc_load, sticky_clr, out_ready;
  logic [15:0] Sum;
  logic        in_ready, out_valid, Op, StickyV;
  logic [15:0] Result, Acc;
  logic [3:0]  Flags;
  logic [1:0]  Occupancy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_result_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Sum(Sum), .Carry(Carry), .Overflow(Overflow), .sel(sel),
    .acc_load(acc_load), .sticky_clr(sticky_clr), .out_valid(out_valid),
    .out_ready(out_ready), .Result(Result), .Flags(Flags), .Op(Op),
    .Acc(Acc), .StickyV(StickyV), .Occupancy(Occupancy)
  );

  typedef struct {
    logic        iv;
    logic [15:0] sum;
    logic        c, v, sel, ld, clr, ordy;
    logic        ev, er;
    logic [15:0] eres;
    logic [3:0]  efl;
    logic        eop;
    logic [15:0] eacc;
    logic        esv;
    logic [1:0]  eocc;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  function automatic vec_t mk(logic iv, logic [15:0] sum, logic c, logic v, logic s,
                              logic ld, logic clr, logic ordy, logic ev, logic er,
                              logic [15:0] eres, logic [3:0] efl, logic eop,
                              logic [15:0] eacc, logic esv, logic [1:0] eocc);
    vec_t t;
    t.iv = iv; t.sum = sum; t.c = c; t.v = v; t.sel = s; t.ld = ld; t.clr = clr;
    t.ordy = ordy; t.ev = ev; t.er = er; t.eres = eres; t.efl = efl; t.eop = eop;
    t.eacc = eacc; t.esv = esv; t.eocc = eocc;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [15:0] s, input logic c, input logic v,
                       input logic op, input logic ld, input logic clr, input logic ordy);
    in_valid = iv; Sum = s; Carry = c; Overflow = v; sel = op;
    acc_load = ld; sticky_clr = clr; out_ready = ordy;
  endtask

  initial begin
    //             iv sum      c  v  sel ld clr or  ev er eres     efl      eop eacc     sv occ
    tbl[0]  = mk(1, 16'h0000, 1, 0, 1, 0, 0, 1,  1, 1, 16'h0000, 4'b0110, 1, 16'h0000, 0, 2'd1);
    tbl[1]  = mk(0, 16'h0000, 0, 0, 0, 0, 0, 1,  0, 1, 16'h0000, 4'b0000, 0, 16'h0000, 0, 2'd0);
    tbl[2]  = mk(1, 16'h1234, 0, 0, 0, 0, 0, 0,  1, 1, 16'h1234, 4'b0000, 0, 16'h0000, 0, 2'd1);
    tbl[3]  = mk(1, 16'h8000, 1, 0, 1, 0, 0, 0,  1, 0, 16'h1234, 4'b0000, 0, 16'h0000, 0, 2'd2);
    tbl[4]  = mk(1, 16'h0001, 0, 0, 0, 0, 0, 0,  1, 0, 16'h1234, 4'b0000, 0, 16'h0000, 0, 2'd2);
    tbl[5]  = mk(1, 16'h0001, 0, 0, 0, 0, 0, 1,  1, 1, 16'h8000, 4'b1010, 1, 16'h0000, 0, 2'd1);
    tbl[6]  = mk(1, 16'h0001, 0, 0, 0, 0, 0, 1,  1, 1, 16'h0001, 4'b0000, 0, 16'h0000, 0, 2'd1);
    tbl[7]  = mk(0, 16'h0000, 0, 0, 0, 0, 0, 1,  0, 1, 16'h0000, 4'b0000, 0, 16'h0000, 0, 2'd0);
    tbl[8]  = mk(1, 16'h00FF, 0, 0, 0, 1, 0, 1,  1, 1, 16'h00FF, 4'b0000, 0, 16'h00FF, 0, 2'd1);
    tbl[9]  = mk(1, 16'h1000, 0, 0, 0, 0, 0, 1,  1, 1, 16'h1000, 4'b0000, 0, 16'h00FF, 0, 2'd1);
    tbl[10] = mk(0, 16'hABCD, 0, 0, 0, 1, 0, 1,  0, 1, 16'h0000, 4'b0000, 0, 16'h00FF, 0, 2'd0);
    tbl[11] = mk(1, 16'h5555, 0, 0, 0, 1, 0, 0,  1, 1, 16'h5555, 4'b0000, 0, 16'h5555, 0, 2'd1);
    tbl[12] = mk(1, 16'h0000, 0, 0, 0, 1, 0, 0,  1, 0, 16'h5555, 4'b0000, 0, 16'h0000, 0, 2'd2);
    tbl[13] = mk(1, 16'h7777, 0, 0, 0, 1, 0, 0,  1, 0, 16'h5555, 4'b0000, 0, 16'h0000, 0, 2'd2);
    tbl[14] = mk(0, 16'h0000, 0, 0, 0, 0, 0, 1,  1, 1, 16'h0000, 4'b0100, 0, 16'h0000, 0, 2'd1);
    tbl[15] = mk(0, 16'h0000, 0, 0, 0, 0, 0, 1,  0, 1, 16'h0000, 4'b0000, 0, 16'h0000, 0, 2'd0);
    tbl[16] = mk(1, 16'h7FFF, 0, 1, 0, 0, 1, 1,  1, 1, 16'h7FFF, 4'b0001, 0, 16'h0000, 1, 2'd1);
    tbl[17] = mk(0, 16'h0000, 0, 0, 0, 0, 1, 1,  0, 1, 16'h0000, 4'b0000, 0, 16'h0000, 0, 2'd0);
    tbl[18] = mk(1, 16'h8000, 1, 1, 0, 0, 0, 1,  1, 1, 16'h8000, 4'b1011, 0, 16'h0000, 1, 2'd1);
    tbl[19] = mk(0, 16'h0000, 0, 0, 0, 0, 0, 1,  0, 1, 16'h0000, 4'b0000, 0, 16'h0000, 1, 2'd0);
    tbl[20] = mk(1, 16'hFFFF, 1, 0, 1, 0, 1, 1,  1, 1, 16'hFFFF, 4'b1010, 1, 16'h0000, 0, 2'd1);
    tbl[21] = mk(0, 16'h0000, 0, 0, 0, 0, 0, 1,  0, 1, 16'h0000, 4'b0000, 0, 16'h0000, 0, 2'd0);

    drive(0, 16'h0000, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occ", Occupancy, 0);
    chk("rst_acc", Acc, 0);
    chk("rst_sticky", StickyV, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].iv, tbl[i].sum, tbl[i].c, tbl[i].v, tbl[i].sel,
            tbl[i].ld, tbl[i].clr, tbl[i].ordy);
      @(posedge clk); #1;
      chk($sformatf("v%0d_out_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("v%0d_in_ready", i), in_ready, tbl[i].er);
      chk($sformatf("v%0d_occ", i), Occupancy, tbl[i].eocc);
      chk($sformatf("v%0d_acc", i), Acc, tbl[i].eacc);
      chk($sformatf("v%0d_sticky", i), StickyV, tbl[i].esv);
      if (tbl[i].ev) begin
        chk($sformatf("v%0d_result", i), Result, tbl[i].eres);
        chk($sformatf("v%0d_flags", i), Flags, tbl[i].efl);
        chk($sformatf("v%0d_op", i), Op, tbl[i].eop);
      end
    end

    // Streaming: one result per cycle, occupancy never above one.
    for (int i = 0; i < 8; i++) begin
      drive(1, 16'(i), 0, 0, 0, 0, 0, 1);
      @(posedge clk); #1;
      chk($sformatf("stream%0d_valid", i), out_valid, 1);
      chk($sformatf("stream%0d_result", i), Result, 16'(i));
      chk($sformatf("stream%0d_occ", i), Occupancy, 1);
      chk($sformatf("stream%0d_zflag", i), Flags, (i == 0) ? 4'b0100 : 4'b0000);
    end
    drive(0, 16'h0000, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    chk("stream_drain_valid", out_valid, 0);

    // Fill to two entries, then reset asynchronously in the middle of a cycle.
    drive(1, 16'h4321, 0, 1, 0, 1, 0, 0);
    @(posedge clk); #1;
    drive(1, 16'h2222, 0, 0, 0, 1, 0, 0);
    @(posedge clk); #1;
    chk("prereset_occ", Occupancy, 2);
    chk("prereset_sticky", StickyV, 1);
    chk("prereset_acc", Acc, 16'h2222);
    drive(0, 16'h0000, 0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_occ", Occupancy, 0);
    chk("async_acc", Acc, 0);
    chk("async_sticky", StickyV, 0);
    chk("async_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 16'h0000, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    chk("postreset_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
